// File: rtl/pipelined_barrel_rotator_pkg.sv
// Shared types for the pipelined barrel rotator: shift mode encoding and
// direction constants used by the interface, the stages and the top.
package shift_pkg;

  typedef enum logic [1:0] {
    ROT  = 2'd0,
    LSH  = 2'd1,
    ASH  = 2'd2,
    RSVD = 2'd3
  } shift_mode_t;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/pipelined_barrel_rotator_if.sv
// Upstream/downstream valid-ready bundle for the barrel rotator.
// master = producer/consumer side (testbench), slave = the rotator.
interface pipelined_barrel_rotator_if
  import shift_pkg::*;
#(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic              up_valid;
  logic              up_ready;
  logic [N-1:0]      up_data;
  logic [SW-1:0]     up_shift;
  logic              up_dir;
  shift_mode_t       up_mode;

  logic              down_valid;
  logic              down_ready;
  logic [N-1:0]      down_data;

  modport master (
    output up_valid, up_data, up_shift, up_dir, up_mode, down_ready,
    input  up_ready, down_valid, down_data
  );

  modport slave (
    input  up_valid, up_data, up_shift, up_dir, up_mode, down_ready,
    output up_ready, down_valid, down_data
  );

endinterface

// File: rtl/pipelined_barrel_rotator_stage.sv
// One pipeline stage of the barrel rotator: conditionally shifts the operand
// by the fixed amount AMT when its select bit of the shift amount is set,
// and registers the result together with valid and side-band fields.
module rotator_stage
  import shift_pkg::*;
#(
  parameter int N   = 8,
  parameter int AMT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  input  logic [$clog2(N)-1:0]   in_shift,
  input  logic                   in_dir,
  input  shift_mode_t            in_mode,
  output logic                   out_valid,
  output logic [N-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_shift,
  output logic                   out_dir,
  output shift_mode_t            out_mode
);

  // Bit of the shift amount that selects this stage.
  localparam int K = $clog2(AMT);

  logic [N-1:0] shifted;

  // Shift by AMT in the requested mode/direction; reserved mode rotates.
  always_comb begin
    shifted = in_data;
    if (in_shift[K]) begin
      case (in_mode)
        LSH: begin
          if (in_dir == SHIFT_RIGHT) shifted = in_data >> AMT;
          else                       shifted = in_data << AMT;
        end
        ASH: begin
          // Sign fill on right shifts; left arithmetic is a plain logical shift.
          if (in_dir == SHIFT_RIGHT) shifted = $signed(in_data) >>> AMT;
          else                       shifted = in_data << AMT;
        end
        default: begin
          if (in_dir == SHIFT_RIGHT) shifted = (in_data >> AMT) | (in_data << (N - AMT));
          else                       shifted = (in_data << AMT) | (in_data >> (N - AMT));
        end
      endcase
    end
  end

  // Stage register: advances only when the whole pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_dir   <= 1'b0;
      out_mode  <= ROT;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_shift <= in_shift;
      out_dir   <= in_dir;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Runtime-programmable N-bit barrel shifter/rotator pipelined as log2(N)
// stages (stage k shifts by 2^k). All stages advance in lockstep whenever the
// output register is empty or being drained; otherwise the pipeline holds.
module pipelined_barrel_rotator
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pipelined_barrel_rotator_if.slave  bus
);

  localparam int SW = $clog2(N);

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_rotator: N must be a power of two and >= 4");
  end

  logic              adv;
  logic              valid_s [SW+1];
  logic [N-1:0]      data_s  [SW+1];
  logic [SW-1:0]     shift_s [SW+1];
  logic              dir_s   [SW+1];
  shift_mode_t       mode_s  [SW+1];

  assign valid_s[0] = bus.up_valid;
  assign data_s[0]  = bus.up_data;
  assign shift_s[0] = bus.up_shift;
  assign dir_s[0]   = bus.up_dir;
  assign mode_s[0]  = bus.up_mode;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    rotator_stage #(
      .N   (N),
      .AMT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (valid_s[k]),
      .in_data   (data_s[k]),
      .in_shift  (shift_s[k]),
      .in_dir    (dir_s[k]),
      .in_mode   (mode_s[k]),
      .out_valid (valid_s[k+1]),
      .out_data  (data_s[k+1]),
      .out_shift (shift_s[k+1]),
      .out_dir   (dir_s[k+1]),
      .out_mode  (mode_s[k+1])
    );
  end

  // Global advance: output slot free or being consumed; bubbles never stall.
  always_comb begin
    adv = !valid_s[SW] || bus.down_ready;
  end

  assign bus.up_ready   = adv;
  assign bus.down_valid = valid_s[SW];
  assign bus.down_data  = data_s[SW];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench for pipelined_barrel_rotator (N = 8): directed vectors,
// back-to-back throughput, backpressure hold, mid-stream reset and a long
// randomized valid/ready run checked against an independent reference model.
module tb_pipelined_barrel_rotator;
  import shift_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipelined_barrel_rotator_if #(.N(N)) bus ();

  pipelined_barrel_rotator #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic [7:0]  sb [$];

  int first_acc = -1;
  int out_first = -1;
  int out_last  = -1;
  int out_cnt   = 0;
  int stall_cnt = 0;
  bit rnd_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Whole-amount reference, computed directly rather than stage by stage.
  function automatic logic [7:0] ref_model(input logic [7:0] d, input logic [2:0] s,
                                           input logic dir, input logic [1:0] m);
    logic [15:0] t;
    logic [7:0]  r;
    t = {d, d};
    if (m == 2'd1) begin
      if (dir) r = d >> s;
      else     r = d << s;
    end else if (m == 2'd2) begin
      if (dir) r = $signed(d) >>> s;
      else     r = d << s;
    end else begin
      if (dir) begin t = t >> s; r = t[7:0];  end
      else     begin t = t << s; r = t[15:8]; end
    end
    return r;
  endfunction

  task automatic reset_window();
    first_acc = -1;
    out_first = -1;
    out_last  = -1;
    out_cnt   = 0;
    stall_cnt = 0;
  endtask

  // Present one transaction and hold it until accepted; push its expectation.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic dir,
                      input logic [1:0] m, input logic [7:0] exp);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    bus.up_shift = s;
    bus.up_dir   = dir;
    bus.up_mode  = shift_mode_t'(m);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.up_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check_eq("accept_timeout", {31'd0, accepted}, 32'd1);
    if (accepted) begin
      sb.push_back(exp);
      if (first_acc < 0) first_acc = cyc;
    end
  endtask

  task automatic send_model(input logic [7:0] d, input logic [2:0] s, input logic dir,
                            input logic [1:0] m);
    send(d, s, dir, m, ref_model(d, s, dir, m));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.up_valid = 1'b0;
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks
  // AXI-style hold of down_valid/down_data across stalls.
  initial begin : monitor
    bit          stall_prev;
    logic [7:0]  prev_data;
    logic [7:0]  exp_d;
    stall_prev = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("hold_valid", {31'd0, bus.down_valid}, 32'd1);
          check_eq("hold_data", {24'd0, bus.down_data}, {24'd0, prev_data});
        end
        check_eq("up_ready", {31'd0, bus.up_ready},
                 {31'd0, (!bus.down_valid || bus.down_ready)});
        if (bus.down_valid && !bus.down_ready) begin
          stall_cnt++;
          check_eq("stall_up_ready", {31'd0, bus.up_ready}, 32'd0);
        end
        if (bus.down_valid && bus.down_ready) begin
          check_eq("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
          if (sb.size() != 0) begin
            exp_d = sb.pop_front();
            check_eq("down_data", {24'd0, bus.down_data}, {24'd0, exp_d});
          end
          if (out_first < 0) out_first = cyc;
          out_last = cyc;
          out_cnt++;
        end
        stall_prev = bus.down_valid && !bus.down_ready;
        prev_data  = bus.down_data;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_shift   = '0;
    bus.up_dir     = 1'b0;
    bus.up_mode    = ROT;
    bus.down_ready = 1'b0;

    #1;
    check_eq("rst_down_valid", {31'd0, bus.down_valid}, 32'd0);
    check_eq("rst_down_data", {24'd0, bus.down_data}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.down_ready = 1'b1;

    // First transaction after reset, with latency measurement.
    reset_window();
    send(8'hB1, 3'd3, SHIFT_RIGHT, 2'd0, 8'h36);
    idle(6);
    check_eq("latency_first", out_first - first_acc, 32'd3);

    // Directed vectors with hand-derived results.
    send(8'hB1, 3'd3, SHIFT_LEFT,  2'd0, 8'h8D);
    send(8'hB1, 3'd0, SHIFT_RIGHT, 2'd0, 8'hB1);
    send(8'hB1, 3'd0, SHIFT_LEFT,  2'd0, 8'hB1);
    send(8'hB1, 3'd3, SHIFT_RIGHT, 2'd1, 8'h16);
    send(8'hB1, 3'd3, SHIFT_RIGHT, 2'd2, 8'hF6);
    send(8'hB1, 3'd3, SHIFT_LEFT,  2'd1, 8'h88);
    send(8'hB1, 3'd3, SHIFT_LEFT,  2'd2, 8'h88);
    send(8'h70, 3'd7, SHIFT_RIGHT, 2'd2, 8'h00);
    send(8'hB1, 3'd0, SHIFT_RIGHT, 2'd1, 8'hB1);
    send(8'hB1, 3'd0, SHIFT_RIGHT, 2'd2, 8'hB1);
    send(8'hB1, 3'd0, SHIFT_LEFT,  2'd3, 8'hB1);
    send(8'hB1, 3'd3, SHIFT_RIGHT, 2'd3, 8'h36);
    idle(6);
    check_eq("directed_drain", sb.size(), 32'd0);

    // Back-to-back throughput: 16 in, 16 out with no bubbles.
    reset_window();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic [3:0] iv;
      d  = 8'($urandom);
      iv = 4'(i);
      send_model(d, iv[2:0], iv[3], 2'(i % 4));
    end
    idle(6);
    check_eq("tput_count", out_cnt, 32'd16);
    check_eq("tput_latency", out_first - first_acc, 32'd3);
    check_eq("tput_no_bubbles", out_last - out_first, 32'd15);
    check_eq("tput_drain", sb.size(), 32'd0);

    // Backpressure: 5-cycle stall of down_ready while the pipeline is full.
    reset_window();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_model(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
        end
        idle(1);
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.down_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.down_ready = 1'b1;
      end
    join
    idle(8);
    check_eq("bp_stall_cycles", stall_cnt, 32'd5);
    check_eq("bp_count", out_cnt, 32'd8);
    check_eq("bp_drain", sb.size(), 32'd0);

    // Reset with a full, stalled pipeline.
    bus.down_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_model(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    idle(4);
    check_eq("pre_reset_valid", {31'd0, bus.down_valid}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, bus.down_valid}, 32'd0);
    check_eq("async_rst_data", {24'd0, bus.down_data}, 32'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    bus.down_ready = 1'b1;
    reset_window();
    send_model(8'h5A, 3'd5, SHIFT_RIGHT, 2'd2);
    idle(6);
    check_eq("latency_after_reset", out_first - first_acc, 32'd3);
    check_eq("count_after_reset", out_cnt, 32'd1);

    // Randomized valid and down_ready toggling.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send_model(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.down_ready = ($urandom_range(0, 3) != 0);
        end
        bus.down_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check_eq("random_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
